// File: rtl/rv32i_mem_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states, requester IDs, width defaults.
package rv32i_mem_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_ADDR = 3'd1,
      D_DATA = 3'd2,
      F_ADDR = 3'd3,
      F_DATA = 3'd4
   } arb_state_t;

   typedef enum logic {
      REQ_IF  = 1'b0,
      REQ_MEM = 1'b1
   } req_id_t;

   function automatic req_id_t owner_of(arb_state_t s);
      return (s == D_ADDR || s == D_DATA) ? REQ_MEM : REQ_IF;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Response watchdog: counts data-phase cycles and saturates at TIMEOUT.
module bus_watchdog #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && cnt_q != LIMIT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store; one transaction in flight.
// IDLE | pick a requester (data first) | *_ADDR | bus_req held until gnt | *_DATA | wait rvalid or watchdog
module mem_port_arbiter
   import rv32i_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_valid,
   input  logic                mem_req,
   input  logic                mem_we,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W/8-1:0] mem_wstrb,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                mem_valid,
   input  logic                flush,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   output logic [DATA_W/8-1:0] bus_wstrb,
   input  logic                bus_gnt,
   input  logic                bus_rvalid,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                stall_if,
   output logic                stall_mem,
   output logic                bus_timeout
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_t        state_q, state_d;
   logic              drop_q, drop_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              mem_valid_q, mem_valid_d;
   logic              timeout_q, timeout_d;
   logic              wd_clear, wd_enable, wd_expired;
   logic              drop_now;
   req_id_t           owner;

   bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_valid_d  = 1'b0;
      mem_valid_d = 1'b0;
      timeout_d   = timeout_q;
      wd_clear    = 1'b0;
      wd_enable   = 1'b0;
      owner       = owner_of(state_q);
      drop_now    = drop_q | flush;

      case (state_q)
         IDLE: begin
            drop_d = 1'b0;
            // A requester whose valid is high this cycle advances on this edge; don't re-issue it.
            if (mem_req && !mem_valid_q) begin
               we_d    = mem_we;
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               state_d = D_ADDR;
            end else if (if_req && !if_valid_q) begin
               we_d    = 1'b0;
               addr_d  = if_addr;
               wdata_d = '0;
               wstrb_d = '0;
               state_d = F_ADDR;
            end
         end
         D_ADDR, F_ADDR: begin
            if (state_q == F_ADDR && flush) drop_d = 1'b1;
            if (bus_gnt) begin
               wd_clear = 1'b1;
               state_d  = (state_q == D_ADDR) ? D_DATA : F_DATA;
            end
         end
         D_DATA, F_DATA: begin
            wd_enable = 1'b1;
            if (state_q == F_DATA && flush) drop_d = 1'b1;
            if (bus_rvalid || wd_expired) begin
               state_d = IDLE;
               drop_d  = 1'b0;
               if (!bus_rvalid) timeout_d = 1'b1;
               if (owner == REQ_MEM) begin
                  mem_rdata_d = bus_rvalid ? bus_rdata : '0;
                  mem_valid_d = 1'b1;
               end else if (!drop_now) begin
                  if_rdata_d = bus_rvalid ? bus_rdata : '0;
                  if_valid_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         drop_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         drop_q      <= drop_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_valid_q  <= if_valid_d;
         mem_valid_q <= mem_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus_req     = (state_q == D_ADDR) || (state_q == F_ADDR);
   assign bus_we      = we_q;
   assign bus_addr    = addr_q;
   assign bus_wdata   = wdata_q;
   assign bus_wstrb   = wstrb_q;
   assign if_rdata    = if_rdata_q;
   assign if_valid    = if_valid_q;
   assign mem_rdata   = mem_rdata_q;
   assign mem_valid   = mem_valid_q;
   assign bus_timeout = timeout_q;
   assign stall_mem   = mem_req & ~mem_valid_q;
   assign stall_if    = stall_mem | (if_req & ~if_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized transactions against a cycle-count model.
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        mem_req = 1'b0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        flush = 1'b0;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_gnt = 1'b0;
   logic        bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = '0;
   logic        stall_if;
   logic        stall_mem;
   logic        bus_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .flush(flush),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .bus_timeout(bus_timeout)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, if_rdata, if_valid, mem_rdata,
           mem_valid, stall_if, stall_mem, bus_timeout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got req=%b addr=%h ifv=%b memv=%b to=%b want all zero",
                  bus_req, bus_addr, if_valid, mem_valid, bus_timeout);
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus_req, if_valid, mem_valid, bus_timeout} !== 4'b0) begin
         errors++;
         $display("FAIL reset_release got %b want 0000", {bus_req, if_valid, mem_valid, bus_timeout});
      end
      next_cycle();
   endtask

   task automatic test_fetch();
      if_req = 1'b1; if_addr = 32'h0000_0040;
      @(negedge clk);
      checks++;
      if ({stall_if, bus_req} !== 2'b10) begin
         errors++; $display("FAIL fetch_c0 got stall_if,bus_req=%b want 10", {stall_if, bus_req});
      end
      next_cycle(); bus_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_wstrb, stall_if} !== {1'b1, 1'b0, 32'h40, 4'h0, 1'b1}) begin
         errors++; $display("FAIL fetch_addr_phase got req=%b we=%b addr=%h strb=%h stall=%b want 1 0 40 0 1",
                            bus_req, bus_we, bus_addr, bus_wstrb, stall_if);
      end
      next_cycle(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0050_0093;
      @(negedge clk);
      checks++;
      if ({bus_req, stall_if, if_valid} !== 3'b010) begin
         errors++; $display("FAIL fetch_c2 got req,stall,valid=%b want 010", {bus_req, stall_if, if_valid});
      end
      next_cycle(); bus_rvalid = 1'b0; bus_rdata = '0;
      @(negedge clk);
      checks++;
      if ({if_valid, stall_if} !== 2'b10 || if_rdata !== 32'h0050_0093) begin
         errors++; $display("FAIL fetch_done got valid=%b stall=%b rdata=%h want 1 0 00500093",
                            if_valid, stall_if, if_rdata);
      end
      next_cycle(); if_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({if_valid, bus_req} !== 2'b00) begin
         errors++; $display("FAIL fetch_no_reissue got valid,req=%b want 00", {if_valid, bus_req});
      end
      next_cycle();
   endtask

   task automatic test_contention();
      if_req = 1'b1; if_addr = 32'h44;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_wdata = '0; mem_wstrb = '0;
      @(negedge clk);
      checks++;
      if ({stall_if, stall_mem} !== 2'b11) begin
         errors++; $display("FAIL cont_stall0 got %b want 11", {stall_if, stall_mem});
      end
      next_cycle(); bus_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus_req, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h100}) begin
         errors++; $display("FAIL cont_data_first got req=%b we=%b addr=%h want 1 0 100", bus_req, bus_we, bus_addr);
      end
      next_cycle(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1122_3344;
      @(negedge clk);
      next_cycle(); bus_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_valid, stall_mem, stall_if, if_valid} !== 4'b1010 || mem_rdata !== 32'h1122_3344) begin
         errors++; $display("FAIL cont_load_done got v,sm,si,ifv=%b rdata=%h want 1010 11223344",
                            {mem_valid, stall_mem, stall_if, if_valid}, mem_rdata);
      end
      next_cycle(); mem_req = 1'b0; bus_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus_req, bus_addr, stall_if, mem_valid} !== {1'b1, 32'h44, 1'b1, 1'b0}) begin
         errors++; $display("FAIL cont_fetch_issue got req=%b addr=%h stall=%b memv=%b want 1 44 1 0",
                            bus_req, bus_addr, stall_if, mem_valid);
      end
      next_cycle(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h00A0_0113;
      @(negedge clk);
      checks++;
      if (stall_if !== 1'b1) begin
         errors++; $display("FAIL cont_stall_held got %b want 1", stall_if);
      end
      next_cycle(); bus_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({if_valid, stall_if} !== 2'b10 || if_rdata !== 32'h00A0_0113) begin
         errors++; $display("FAIL cont_fetch_done got v=%b stall=%b rdata=%h want 1 0 00a00113",
                            if_valid, stall_if, if_rdata);
      end
      next_cycle(); if_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_store();
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b0011;
      @(negedge clk);
      checks++;
      if (stall_mem !== 1'b1) begin
         errors++; $display("FAIL store_stall got %b want 1", stall_mem);
      end
      for (int c = 1; c <= 2; c++) begin
         next_cycle();
         bus_gnt = (c == 2);
         if (c == 2) mem_wdata = 32'h0;
         @(negedge clk);
         checks++;
         if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb} !==
             {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011}) begin
            errors++; $display("FAIL store_fields c%0d got req=%b we=%b addr=%h wdata=%h strb=%b",
                               c, bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb);
         end
      end
      next_cycle(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0;
      @(negedge clk);
      checks++;
      if ({mem_valid, bus_req} !== 2'b00) begin
         errors++; $display("FAIL store_ack_cycle got v,req=%b want 00", {mem_valid, bus_req});
      end
      next_cycle(); bus_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_valid, stall_mem} !== 2'b10) begin
         errors++; $display("FAIL store_done got v,stall=%b want 10", {mem_valid, stall_mem});
      end
      next_cycle(); mem_req = 1'b0; mem_we = 1'b0; mem_wstrb = '0;
      next_cycle();
   endtask

   task automatic test_flush();
      if_req = 1'b1; if_addr = 32'h48;
      next_cycle(); bus_gnt = 1'b1;
      next_cycle(); bus_gnt = 1'b0; flush = 1'b1;
      next_cycle(); flush = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0; if_req = 1'b0;
      next_cycle(); bus_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({if_valid, bus_req} !== 2'b00 || if_rdata !== 32'h00A0_0113) begin
         errors++; $display("FAIL flush_drop got v=%b req=%b rdata=%h want 0 0 00a00113",
                            if_valid, bus_req, if_rdata);
      end
      next_cycle(); if_req = 1'b1; if_addr = 32'h80;
      next_cycle(); bus_gnt = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus_req, bus_addr} !== {1'b1, 32'h80}) begin
         errors++; $display("FAIL flush_next_issue got req=%b addr=%h want 1 80", bus_req, bus_addr);
      end
      next_cycle(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0000_0013;
      next_cycle(); bus_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if (if_valid !== 1'b1 || if_rdata !== 32'h0000_0013) begin
         errors++; $display("FAIL flush_next_done got v=%b rdata=%h want 1 00000013", if_valid, if_rdata);
      end
      next_cycle(); if_req = 1'b0;
      next_cycle();
   endtask

   // rvalid in the very cycle the counter reaches TIMEOUT still completes normally.
   task automatic test_rvalid_boundary();
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300;
      next_cycle(); bus_gnt = 1'b1;
      next_cycle(); bus_gnt = 1'b0;
      for (int t = 2; t <= TIMEOUT + 4; t++) begin
         bus_rvalid = (t == TIMEOUT + 2);
         bus_rdata  = (t == TIMEOUT + 2) ? 32'h5A5A_1234 : 32'hFFFF_FFFF;
         if (t == TIMEOUT + 4) mem_req = 1'b0;
         @(negedge clk);
         checks++;
         if (mem_valid !== (t == TIMEOUT + 3)) begin
            errors++; $display("FAIL bound_valid t=%0d got %b", t, mem_valid);
         end
         if (t == TIMEOUT + 3) begin
            checks++;
            if (mem_rdata !== 32'h5A5A_1234 || bus_timeout !== 1'b0) begin
               errors++; $display("FAIL bound_data got rdata=%h to=%b want 5a5a1234 0", mem_rdata, bus_timeout);
            end
         end
         next_cycle();
      end
      bus_rvalid = 1'b0; bus_rdata = '0;
      next_cycle();
   endtask

   task automatic test_random(input int iters);
      int          kind, fmode, ntx, fi, vm, vf, fs, flush_t, end_t, txi, phase, cnt;
      bit          has_mem, has_if, if_flushed, is_store, exp_sm, exp_si;
      int          g[2];
      int          r[2];
      logic [31:0] rd[2];
      logic [31:0] e_addr[2];
      logic [31:0] e_wdata[2];
      logic        e_we[2];
      logic [3:0]  e_wstrb[2];
      for (int it = 0; it < iters; it++) begin
         kind     = $urandom_range(0, 4);
         has_mem  = (kind != 0);
         has_if   = (kind == 0) || (kind >= 3);
         is_store = (kind == 2) || (kind == 4);
         ntx = 0;
         if (has_mem) begin
            e_we[0]    = is_store;
            e_addr[0]  = $urandom & 32'hFFFF_FFFC;
            e_wdata[0] = $urandom;
            e_wstrb[0] = is_store ? 4'($urandom_range(1, 15)) : 4'h0;
            ntx = 1;
         end
         fi = ntx;
         if (has_if) begin
            e_we[fi] = 1'b0; e_addr[fi] = $urandom & 32'hFFFF_FFFC; e_wdata[fi] = '0; e_wstrb[fi] = 4'h0;
            ntx++;
         end
         for (int k = 0; k < 2; k++) begin
            g[k] = $urandom_range(0, 3); r[k] = $urandom_range(0, 5); rd[k] = $urandom;
         end
         // request sampled at 0, valid 3 + gnt wait + rvalid wait; fetch behind data starts at data's valid cycle
         vm = has_mem ? 3 + g[0] + r[0] : -10;
         fs = has_mem ? vm : 0;
         vf = has_if ? fs + 3 + g[fi] + r[fi] : -10;
         fmode = $urandom_range(0, 3);
         flush_t = -10; if_flushed = 1'b0;
         if (fmode == 1 && has_if) begin
            flush_t = $urandom_range(fs + 1, fs + 2 + g[fi] + r[fi]);
            if_flushed = 1'b1;
         end else if (fmode == 2 && has_mem) begin
            flush_t = $urandom_range(0, vm);
         end
         end_t = (has_if ? vf : vm) + 2;
         txi = 0; phase = 0; cnt = 0;
         for (int t = 0; t <= end_t; t++) begin
            if (t == 0) begin
               if (has_mem) begin
                  mem_req = 1'b1; mem_we = e_we[0]; mem_addr = e_addr[0];
                  mem_wdata = e_wdata[0]; mem_wstrb = e_wstrb[0];
               end
               if (has_if) begin
                  if_req = 1'b1; if_addr = e_addr[fi];
               end
            end
            if (t == vm + 1) begin mem_req = 1'b0; mem_we = 1'b0; end
            if (t == vf + 1 || (if_flushed && t == flush_t + 1)) if_req = 1'b0;
            flush = (t == flush_t);
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
            if (phase == 0 && bus_req) begin
               checks++;
               if (txi >= ntx) begin
                  errors++; $display("FAIL rnd_extra_req it=%0d t=%0d addr=%h", it, t, bus_addr);
                  phase = 3;
               end else begin
                  if ({bus_we, bus_addr, bus_wstrb} !== {e_we[txi], e_addr[txi], e_wstrb[txi]} ||
                      (e_we[txi] && bus_wdata !== e_wdata[txi])) begin
                     errors++; $display("FAIL rnd_bus_fields it=%0d tx=%0d got we=%b addr=%h strb=%h wdata=%h want %b %h %h %h",
                                        it, txi, bus_we, bus_addr, bus_wstrb, bus_wdata,
                                        e_we[txi], e_addr[txi], e_wstrb[txi], e_wdata[txi]);
                  end
                  phase = 1; cnt = 0;
               end
            end
            if (phase == 1) begin
               if (cnt == g[txi]) begin bus_gnt = 1'b1; phase = 2; cnt = 0; end
               else cnt++;
            end else if (phase == 2) begin
               if (cnt == r[txi]) begin bus_rvalid = 1'b1; bus_rdata = rd[txi]; phase = 0; txi++; end
               else cnt++;
            end
            @(negedge clk);
            exp_sm = mem_req && (t != vm);
            exp_si = exp_sm || (if_req && !(t == vf && !if_flushed));
            checks++;
            if ({stall_mem, stall_if} !== {exp_sm, exp_si}) begin
               errors++; $display("FAIL rnd_stall it=%0d t=%0d got %b%b want %b%b",
                                  it, t, stall_mem, stall_if, exp_sm, exp_si);
            end
            checks++;
            if (mem_valid !== (t == vm)) begin
               errors++; $display("FAIL rnd_mem_valid it=%0d t=%0d got %b want %b", it, t, mem_valid, (t == vm));
            end
            checks++;
            if (if_valid !== (t == vf && !if_flushed)) begin
               errors++; $display("FAIL rnd_if_valid it=%0d t=%0d got %b want %b flushed=%b",
                                  it, t, if_valid, (t == vf && !if_flushed), if_flushed);
            end
            if (t == vm && !e_we[0]) begin
               checks++;
               if (mem_rdata !== rd[0]) begin
                  errors++; $display("FAIL rnd_mem_rdata it=%0d got %h want %h", it, mem_rdata, rd[0]);
               end
            end
            if (t == vf && !if_flushed) begin
               checks++;
               if (if_rdata !== rd[fi]) begin
                  errors++; $display("FAIL rnd_if_rdata it=%0d got %h want %h", it, if_rdata, rd[fi]);
               end
            end
            next_cycle();
         end
         checks++;
         if (txi != ntx) begin
            errors++; $display("FAIL rnd_tx_count it=%0d got %0d want %0d", it, txi, ntx);
         end
         mem_req = 1'b0; if_req = 1'b0; flush = 1'b0;
         bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      end
      next_cycle();
   endtask

   task automatic test_watchdog();
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500; mem_wstrb = '0;
      next_cycle(); bus_gnt = 1'b1;
      next_cycle(); bus_gnt = 1'b0;
      for (int t = 2; t <= TIMEOUT + 5; t++) begin
         if (t == TIMEOUT + 4) mem_req = 1'b0;
         @(negedge clk);
         checks++;
         if (mem_valid !== (t == TIMEOUT + 3)) begin
            errors++; $display("FAIL wd_valid t=%0d got %b want %b", t, mem_valid, (t == TIMEOUT + 3));
         end
         checks++;
         if (bus_timeout !== (t >= TIMEOUT + 3)) begin
            errors++; $display("FAIL wd_flag t=%0d got %b want %b", t, bus_timeout, (t >= TIMEOUT + 3));
         end
         if (t == TIMEOUT + 3) begin
            checks++;
            if (mem_rdata !== 32'h0) begin
               errors++; $display("FAIL wd_rdata got %h want 0", mem_rdata);
            end
         end
         next_cycle();
      end
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_0000;
      next_cycle(); bus_rvalid = 1'b0; bus_rdata = '0;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         checks++;
         if ({mem_valid, if_valid, bus_req, bus_timeout} !== 4'b0001 || mem_rdata !== 32'h0) begin
            errors++; $display("FAIL wd_stray t=%0d got v,ifv,req,to=%b rdata=%h want 0001 0",
                               t, {mem_valid, if_valid, bus_req, bus_timeout}, mem_rdata);
         end
         next_cycle();
      end
   endtask

   task automatic test_async_reset();
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600;
      next_cycle(); bus_gnt = 1'b1;
      next_cycle(); bus_gnt = 1'b0;
      #2;
      rst = 1'b1; mem_req = 1'b0;
      #1;
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, if_rdata, if_valid, mem_rdata,
           mem_valid, stall_if, stall_mem, bus_timeout} !== '0) begin
         errors++; $display("FAIL areset_outputs got addr=%h rdata=%h to=%b want all zero",
                            bus_addr, mem_rdata, bus_timeout);
      end
      next_cycle(); rst = 1'b0;
      next_cycle(); bus_rvalid = 1'b1; bus_rdata = 32'h0000_1234;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         checks++;
         if ({mem_valid, if_valid, bus_req, bus_timeout} !== 4'b0000) begin
            errors++; $display("FAIL areset_after t=%0d got %b want 0000",
                               t, {mem_valid, if_valid, bus_req, bus_timeout});
         end
         next_cycle(); bus_rvalid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1;
      next_cycle();
      next_cycle();
      test_reset();
      test_fetch();
      test_contention();
      test_store();
      test_flush();
      test_rvalid_boundary();
      test_random(60);
      test_watchdog();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
